// File: rtl/yarp_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package yarp_pkg;

    localparam int unsigned PF_XLEN     = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        PF_RESET_WAIT = 2'd0,
        PF_RUN        = 2'd1,
        PF_HALT       = 2'd2
    } pf_state_e;

    typedef struct packed {
        logic [PF_XLEN-1:0] pc;
        logic [31:0]        instr;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous prefetch FIFO with flush. Same-cycle push and pop are
// legal at any occupancy, including full.
module prefetch_fifo
    import yarp_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_C);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    // a pop in the same cycle frees the slot the push lands in
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // storage array; contents are only meaningful below the count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // pointers and occupancy, cleared by reset or flush
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch front-end: keeps up to MAX_OUTSTANDING requests in
// flight, buffers in-order responses in a DEPTH-entry FIFO and hands
// {pc, instr} to decode. Redirect flushes and discards stale responses.
// Optional macro PREFETCH_MISALIGN_EN: misaligned redirect halts fetch and
// raises a sticky fetch_misaligned_o until reset or an aligned redirect.
module prefetch_unit
    import yarp_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(32'h1000)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            instr_mem_req_o,
    output logic [XLEN-1:0] instr_mem_addr_o,
    input  logic            instr_mem_gnt_i,
    input  logic            instr_mem_rvalid_i,
    input  logic [31:0]     instr_mem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
`ifdef PREFETCH_MISALIGN_EN
    ,
    output logic            fetch_misaligned_o
`endif
);

    localparam int unsigned CW  = $clog2(DEPTH+1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned FW  = XLEN + 32;
    localparam logic [CW-1:0]   MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]     DEPTH_C   = CW1'(DEPTH);
    localparam logic [XLEN-1:0] STEP_C    = XLEN'(INSTR_BYTES);

    pf_state_e       r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;

    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic [FW-1:0]   w_fifo_rdata;
    logic [CW:0]     w_inflight;
    logic            w_req;
    logic            w_grant;
    logic            w_rv;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_out_next;
    logic [XLEN-1:0] w_redir_pc;

`ifdef PREFETCH_MISALIGN_EN
    logic            r_misaligned;
    logic            w_redir_misaligned;

    assign w_redir_misaligned = |redirect_pc_i[1:0];
    assign fetch_misaligned_o = r_misaligned;
`else
    logic            w_unused_lsbs;

    assign w_unused_lsbs = ^redirect_pc_i[1:0];
`endif

    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_req      = (r_state == PF_RUN) && (r_outstanding < MAX_OUT_C) &&
                        (w_inflight < DEPTH_C) && !redirect_i;
    assign w_grant    = w_req && instr_mem_gnt_i;
    // a response with nothing outstanding cannot be ours
    assign w_rv       = instr_mem_rvalid_i && (r_outstanding != '0);
    assign w_out_next = r_outstanding + {{(CW-1){1'b0}}, w_grant}
                                      - {{(CW-1){1'b0}}, w_rv};
    assign w_push     = w_rv && !redirect_i && (r_discard == '0);
    assign w_pop      = instr_valid_o && instr_ready_i && !redirect_i;
    assign w_redir_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

    assign instr_mem_req_o  = w_req;
    assign instr_mem_addr_o = r_fetch_pc;
    assign instr_valid_o    = !w_fifo_empty;
    assign instr_o          = instr_valid_o ? w_fifo_rdata[31:0] : '0;
    assign instr_pc_o       = instr_valid_o ? w_fifo_rdata[FW-1:32] : '0;

    prefetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({r_resp_pc, instr_mem_rdata_i}),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // fetch control: state, PCs, outstanding and discard counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= PF_RESET_WAIT;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
`ifdef PREFETCH_MISALIGN_EN
            r_misaligned  <= 1'b0;
`endif
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_i) begin
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                // everything still owed after this edge belongs to the old stream
                r_discard  <= w_out_next;
`ifdef PREFETCH_MISALIGN_EN
                if (w_redir_misaligned) begin
                    r_state      <= PF_HALT;
                    r_misaligned <= 1'b1;
                end else begin
                    r_state      <= PF_RUN;
                    r_misaligned <= 1'b0;
                end
`else
                r_state    <= PF_RUN;
`endif
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + STEP_C;
                end
                if (w_rv) begin
                    if (r_discard != '0) begin
                        r_discard <= r_discard - CW'(1);
                    end else begin
                        r_resp_pc <= r_resp_pc + STEP_C;
                    end
                end
                if (r_state == PF_RESET_WAIT) begin
                    r_state <= PF_RUN;
                end
            end
        end
    end

    // the credit rule must keep a push from ever meeting a full FIFO without a pop
    assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_prefetch_unit.sv
// Randomized bench for prefetch_unit. The reference model tags every
// granted request with a stream epoch; responses of a stale epoch are
// dropped and the rest form the expected {pc, instr} delivery queue.
`timescale 1ns/1ps
module tb_prefetch_unit;
    import yarp_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_mem_req_o;
    logic [31:0] instr_mem_addr_o;
    logic        instr_mem_gnt_i;
    logic        instr_mem_rvalid_i;
    logic [31:0] instr_mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
`ifdef PREFETCH_MISALIGN_EN
    logic        fetch_misaligned_o;
`endif

    always #5 clk = ~clk;

    prefetch_unit #(
        .XLEN            (32),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .instr_mem_req_o    (instr_mem_req_o),
        .instr_mem_addr_o   (instr_mem_addr_o),
        .instr_mem_gnt_i    (instr_mem_gnt_i),
        .instr_mem_rvalid_i (instr_mem_rvalid_i),
        .instr_mem_rdata_i  (instr_mem_rdata_i),
        .redirect_i         (redirect_i),
        .redirect_pc_i      (redirect_pc_i),
        .instr_valid_o      (instr_valid_o),
        .instr_o            (instr_o),
        .instr_pc_o         (instr_pc_o),
        .instr_ready_i      (instr_ready_i)
`ifdef PREFETCH_MISALIGN_EN
        ,
        .fetch_misaligned_o (fetch_misaligned_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } mreq_t;

    mreq_t        memq[$];
    fetch_entry_t mq[$];
    int unsigned  epoch;
    int unsigned  cyc;
    logic [31:0]  exp_issue;
    bit           running;
    bit           halted;
    int unsigned  n_checks;
    int unsigned  n_pass;
    int unsigned  phase_grants;
    int unsigned  k_gnt, k_ready, k_redir, k_spur, k_rst, lat_min, lat_max;
    bit           force_redir;
    logic [31:0]  force_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic bit chance(input int unsigned pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    function automatic logic [31:0] pick_pc();
        logic [31:0] p;
        p = $urandom;
        if ($urandom_range(9, 0) < 2) p[31:4] = 28'hfff_ffff;
        if ($urandom_range(3, 0) != 0) p[1:0] = 2'b00;
        return p;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic run_cycle(input bit rst_req);
        bit           do_rst, exp_req, exp_valid, redir, gnt, rv, rdy;
        logic [31:0]  rpc;
        logic [31:0]  rdata;
        mreq_t        r;
        fetch_entry_t e;
        @(negedge clk);
        do_rst = rst_req || chance(k_rst);
        gnt    = chance(k_gnt);
        rdy    = chance(k_ready);
        redir  = 1'b0;
        rpc    = '0;
        rv     = 1'b0;
        rdata  = $urandom;
        if (!do_rst) begin
            if (force_redir) begin
                redir       = 1'b1;
                rpc         = force_pc;
                force_redir = 1'b0;
            end else if (chance(k_redir)) begin
                redir = 1'b1;
                rpc   = pick_pc();
            end
            if (memq.size() != 0) begin
                if (memq[0].due <= cyc) begin
                    rv    = 1'b1;
                    rdata = mem_word(memq[0].addr);
                end
            end else if (chance(k_spur)) begin
                rv = 1'b1;
            end
        end
        reset              = do_rst;
        instr_mem_gnt_i    = gnt;
        instr_mem_rvalid_i = rv;
        instr_mem_rdata_i  = rdata;
        redirect_i         = redir;
        redirect_pc_i      = rpc;
        instr_ready_i      = rdy;
        #1;
        if (do_rst) begin
            memq.delete();
            mq.delete();
            epoch++;
            exp_issue = RST_PC;
            running   = 1'b0;
            halted    = 1'b0;
        end else begin
            exp_req   = running && !halted && (memq.size() < MAXO) &&
                        (memq.size() + mq.size() < DEPTH) && !redir;
            exp_valid = (mq.size() != 0);
            check_eq("req", 32'(instr_mem_req_o), 32'(exp_req));
            if (exp_req) check_eq("addr", instr_mem_addr_o, exp_issue);
            check_eq("valid", 32'(instr_valid_o), 32'(exp_valid));
            if (exp_valid) begin
                check_eq("pc", instr_pc_o, mq[0].pc);
                check_eq("instr", instr_o, mq[0].instr);
            end
`ifdef PREFETCH_MISALIGN_EN
            check_eq("misaligned", 32'(fetch_misaligned_o), 32'(halted));
`endif
            if (instr_mem_req_o && gnt) phase_grants++;
            if (exp_valid && rdy && !redir) void'(mq.pop_front());
            if (rv && memq.size() != 0) begin
                r = memq.pop_front();
                if (!redir && r.epoch == epoch) begin
                    e.pc    = r.addr;
                    e.instr = mem_word(r.addr);
                    mq.push_back(e);
                end
            end
            if (exp_req && gnt) begin
                r.addr  = exp_issue;
                r.epoch = epoch;
                r.due   = cyc + $urandom_range(lat_max, lat_min);
                memq.push_back(r);
                exp_issue += 32'd4;
            end
            if (redir) begin
                mq.delete();
                epoch++;
                exp_issue = {rpc[31:2], 2'b00};
`ifdef PREFETCH_MISALIGN_EN
                halted = (rpc[1:0] != 2'b00);
`endif
            end
            running = 1'b1;
        end
        cyc++;
    endtask

    initial begin
        reset              = 1'b1;
        instr_mem_gnt_i    = 1'b0;
        instr_mem_rvalid_i = 1'b0;
        instr_mem_rdata_i  = '0;
        redirect_i         = 1'b0;
        redirect_pc_i      = '0;
        instr_ready_i      = 1'b0;
        n_checks = 0; n_pass = 0; epoch = 0; cyc = 0; phase_grants = 0;
        exp_issue = RST_PC; running = 1'b0; halted = 1'b0;
        force_redir = 1'b0; force_pc = '0;
        k_gnt = 100; k_ready = 100; k_redir = 0; k_spur = 0; k_rst = 0;
        lat_min = 1; lat_max = 1;

        // streaming with an ideal memory and consumer
        repeat (3) run_cycle(1'b1);
        repeat (20) run_cycle(1'b0);

        // consumer stalled: credits stop issue once the FIFO would fill
        k_ready = 0;
        repeat (2) run_cycle(1'b1);
        phase_grants = 0;
        repeat (12) run_cycle(1'b0);
        check_eq("grants_ready0", 32'(phase_grants), 32'd4);
        k_ready = 100;
        repeat (12) run_cycle(1'b0);

        // slow memory with requests in flight, then redirect
        lat_min = 5; lat_max = 5;
        repeat (4) run_cycle(1'b0);
        force_redir = 1'b1; force_pc = 32'h2000;
        repeat (25) run_cycle(1'b0);

        // random traffic
        k_gnt = 60; k_ready = 60; k_redir = 4; k_spur = 5;
        lat_min = 1; lat_max = 6;
        repeat (3000) run_cycle(1'b0);

        // random traffic with occasional mid-operation reset
        k_rst = 1;
        repeat (1000) run_cycle(1'b0);
        k_rst = 0;

        // misaligned redirect followed by an aligned one
        k_redir = 0; k_spur = 0; k_gnt = 100; k_ready = 100;
        lat_min = 1; lat_max = 3;
        force_redir = 1'b1; force_pc = 32'h2002;
        repeat (10) run_cycle(1'b0);
        force_redir = 1'b1; force_pc = 32'h4000;
        repeat (15) run_cycle(1'b0);

        // address wrap-around
        force_redir = 1'b1; force_pc = 32'hffff_fff0;
        repeat (20) run_cycle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
